// File: rtl/fetch_unit.sv
// fetch_unit: owns the program counter, looks up the instruction cache and
// buffers hits in a small in-order {pc, instr} queue drained by decode.
// Redirects reload the PC and discard queued work; fence.i produces a
// one-cycle cache flush pulse and a short two-cycle fetch pause.
module fetch_unit #(
  parameter int                    ADDR_WIDTH  = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    QUEUE_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic [ADDR_WIDTH-1:0] icache_addr,
  input  logic [31:0]           icache_instr,
  input  logic                  icache_valid,
  output logic                  icache_stall,
  output logic                  icache_flush,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  fence_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [31:0]           out_instr,
  output logic [31:0]           miss_cycles
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);

  typedef enum logic [2:0] {BOOT, FETCH, MISS, FULL, FLUSHING} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
  logic [PTR_W:0]        wr_ptr_reg, wr_ptr_next;
  logic [PTR_W:0]        rd_ptr_reg, rd_ptr_next;
  logic                  flush_cnt_reg, flush_cnt_next;
  logic [31:0]           miss_cycles_reg;

  logic [ADDR_WIDTH-1:0] q_pc    [QUEUE_DEPTH];
  logic [31:0]           q_instr [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] wr_en;

  logic push, pop, full, empty, can_push;
  logic [PTR_W-1:0] wr_idx, rd_idx;

  assign wr_idx   = wr_ptr_reg[PTR_W-1:0];
  assign rd_idx   = rd_ptr_reg[PTR_W-1:0];
  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_idx == rd_idx) && (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]);
  assign pop      = out_valid & out_ready;
  assign can_push = !full | pop;

  // Head of queue is exposed combinationally; an empty queue shows zeros.
  assign out_valid   = !empty;
  assign out_pc      = empty ? '0 : q_pc[rd_idx];
  assign out_instr   = empty ? '0 : q_instr[rd_idx];

  assign icache_addr  = pc_reg;
  assign icache_stall = (state_reg == BOOT) | (state_reg == FULL) |
                        (state_reg == FLUSHING) | full;
  assign icache_flush = (state_reg == FLUSHING) && !flush_cnt_reg;
  assign miss_cycles  = miss_cycles_reg;

  // Queue storage: one register pair per entry, written only when the
  // write pointer selects it.
  generate
    for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_entry
      logic [ADDR_WIDTH-1:0] pc_q;
      logic [31:0]           instr_q;

      assign wr_en[gi]   = push && (wr_idx == PTR_W'(gi));
      assign q_pc[gi]    = pc_q;
      assign q_instr[gi] = instr_q;

      // Capture the fetched pair when this entry is the write target.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          pc_q    <= '0;
          instr_q <= '0;
        end else if (wr_en[gi]) begin
          pc_q    <= pc_reg;
          instr_q <= icache_instr;
        end
      end
    end
  endgenerate

  // Next-state, PC and push decision; redirect beats fence.i beats fetch.
  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    flush_cnt_next = flush_cnt_reg;
    push           = 1'b0;
    if (redirect_valid) begin
      pc_next        = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      state_next     = FETCH;
      flush_cnt_next = 1'b0;
    end else if (fence_i) begin
      state_next     = FLUSHING;
      flush_cnt_next = 1'b0;
    end else begin
      case (state_reg)
        BOOT: state_next = FETCH;
        FETCH, MISS: begin
          if (!icache_valid) begin
            state_next = MISS;
          end else if (can_push) begin
            push       = 1'b1;
            pc_next    = pc_reg + ADDR_WIDTH'(4);
            state_next = FETCH;
          end else begin
            state_next = FULL;
          end
        end
        FULL: begin
          if (can_push) begin
            if (icache_valid) begin
              push       = 1'b1;
              pc_next    = pc_reg + ADDR_WIDTH'(4);
              state_next = FETCH;
            end else begin
              state_next = MISS;
            end
          end
        end
        FLUSHING: begin
          if (flush_cnt_reg) state_next = FETCH;
          else               flush_cnt_next = 1'b1;
        end
        default: state_next = BOOT;
      endcase
    end
  end

  // Pointer updates; a redirect empties the queue and drops any pop.
  always_comb begin
    wr_ptr_next = wr_ptr_reg + (PTR_W+1)'(push);
    rd_ptr_next = rd_ptr_reg + (PTR_W+1)'(pop);
    if (redirect_valid) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end
  end

  // State, PC, pointer and flush-counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= BOOT;
      pc_reg        <= RESET_PC;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      flush_cnt_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  // Count every cycle spent in MISS, saturating at all ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      miss_cycles_reg <= '0;
    end else if (state_reg == MISS && miss_cycles_reg != 32'hFFFF_FFFF) begin
      miss_cycles_reg <= miss_cycles_reg + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed per-cycle vectors for boot, backpressure,
// redirect and fence.i, plus hand sequences for a long miss and an
// asynchronous reset taken in the middle of a miss.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] icache_addr;
  logic [31:0] icache_instr;
  logic        icache_valid;
  logic        icache_stall;
  logic        icache_flush;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        fence_i;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] miss_cycles;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.ADDR_WIDTH(64), .RESET_PC(64'h0), .QUEUE_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .icache_addr(icache_addr), .icache_instr(icache_instr),
    .icache_valid(icache_valid), .icache_stall(icache_stall),
    .icache_flush(icache_flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .fence_i(fence_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .miss_cycles(miss_cycles)
  );

  always #5 clk = ~clk;

  // Cache model: the word at an address is a tag plus the low address bits.
  function automatic logic [31:0] word_at(input logic [63:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  assign icache_instr = word_at(icache_addr);

  typedef struct {
    logic        rdy;
    logic        iv;
    logic        redir;
    logic [63:0] rpc;
    logic        fence;
    logic        e_valid;
    logic [63:0] e_pc;
    logic [63:0] e_addr;
    logic        e_stall;
    logic        e_flush;
    logic [31:0] e_miss;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(input logic rdy, input logic iv, input logic redir,
                              input logic [63:0] rpc, input logic fence,
                              input logic e_valid, input logic [63:0] e_pc,
                              input logic [63:0] e_addr, input logic e_stall,
                              input logic e_flush, input logic [31:0] e_miss);
    vec_t v;
    v.rdy = rdy; v.iv = iv; v.redir = redir; v.rpc = rpc; v.fence = fence;
    v.e_valid = e_valid; v.e_pc = e_pc; v.e_addr = e_addr;
    v.e_stall = e_stall; v.e_flush = e_flush; v.e_miss = e_miss;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic e_valid, input logic [63:0] e_pc,
                             input logic [63:0] e_addr, input logic e_stall,
                             input logic e_flush, input logic [31:0] e_miss);
    logic [31:0] e_instr;
    e_instr = e_valid ? word_at(e_pc) : 32'h0;
    chk({tag, " out_valid"},    {63'h0, out_valid},    {63'h0, e_valid});
    chk({tag, " out_pc"},       out_pc,                e_pc);
    chk({tag, " out_instr"},    {32'h0, out_instr},    {32'h0, e_instr});
    chk({tag, " icache_addr"},  icache_addr,           e_addr);
    chk({tag, " icache_stall"}, {63'h0, icache_stall}, {63'h0, e_stall});
    chk({tag, " icache_flush"}, {63'h0, icache_flush}, {63'h0, e_flush});
    chk({tag, " miss_cycles"},  {32'h0, miss_cycles},  {32'h0, e_miss});
    $display("%s: valid=%0b pc=%h addr=%h stall=%0b flush=%0b miss=%0d",
             tag, out_valid, out_pc, icache_addr, icache_stall, icache_flush, miss_cycles);
  endtask

  task automatic drive(input logic rdy, input logic iv, input logic redir,
                       input logic [63:0] rpc, input logic fence);
    out_ready = rdy; icache_valid = iv; redirect_valid = redir;
    redirect_pc = rpc; fence_i = fence;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // Boot: hits at 0..C with decode ready.
    vecs[0]  = mk(1,1,0,64'h0,0,    0,64'h0,   64'h0,   1,0,0);
    vecs[1]  = mk(1,1,0,64'h0,0,    0,64'h0,   64'h0,   0,0,0);
    vecs[2]  = mk(1,1,0,64'h0,0,    1,64'h0,   64'h4,   0,0,0);
    vecs[3]  = mk(1,1,0,64'h0,0,    1,64'h4,   64'h8,   0,0,0);
    vecs[4]  = mk(1,1,0,64'h0,0,    1,64'h8,   64'hC,   0,0,0);
    // Backpressure: queue fills, goes FULL, one pop lets one push in.
    vecs[5]  = mk(0,1,0,64'h0,0,    1,64'hC,   64'h10,  0,0,0);
    vecs[6]  = mk(0,1,0,64'h0,0,    1,64'hC,   64'h14,  0,0,0);
    vecs[7]  = mk(0,1,0,64'h0,0,    1,64'hC,   64'h18,  0,0,0);
    vecs[8]  = mk(0,1,0,64'h0,0,    1,64'hC,   64'h1C,  1,0,0);
    vecs[9]  = mk(1,1,0,64'h0,0,    1,64'hC,   64'h1C,  1,0,0);
    vecs[10] = mk(1,0,0,64'h0,0,    1,64'h10,  64'h20,  1,0,0);
    // Redirect with 3 queued entries and a concurrent pop.
    vecs[11] = mk(1,0,1,64'h1003,0, 1,64'h14,  64'h20,  0,0,0);
    vecs[12] = mk(1,1,0,64'h0,0,    0,64'h0,   64'h1000,0,0,1);
    vecs[13] = mk(0,1,0,64'h0,0,    1,64'h1000,64'h1004,0,0,1);
    // fence.i: one flush pulse, two idle cycles, queue preserved.
    vecs[14] = mk(0,1,0,64'h0,1,    1,64'h1000,64'h1008,0,0,1);
    vecs[15] = mk(0,1,0,64'h0,0,    1,64'h1000,64'h1008,1,1,1);
    vecs[16] = mk(0,1,0,64'h0,0,    1,64'h1000,64'h1008,1,0,1);
    vecs[17] = mk(1,1,0,64'h0,0,    1,64'h1000,64'h1008,0,0,1);
    // fence.i aborted by a redirect in its first FLUSHING cycle.
    vecs[18] = mk(0,1,0,64'h0,1,    1,64'h1004,64'h100C,0,0,1);
    vecs[19] = mk(0,1,1,64'h2000,0, 1,64'h1004,64'h100C,1,1,1);
    vecs[20] = mk(1,0,0,64'h0,0,    0,64'h0,   64'h2000,0,0,1);

    reset_n = 1'b0;
    drive(0,0,0,64'h0,0);
    next_cycle();
    next_cycle();
    chk_outputs("reset", 0, 64'h0, 64'h0, 1, 0, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].rdy, vecs[i].iv, vecs[i].redir, vecs[i].rpc, vecs[i].fence);
      #1;
      chk_outputs($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pc,
                  vecs[i].e_addr, vecs[i].e_stall, vecs[i].e_flush, vecs[i].e_miss);
      next_cycle();
    end

    // Long miss: vec20 was the first invalid cycle, six more follow in MISS.
    for (int i = 0; i < 6; i++) begin
      drive(1,0,0,64'h0,0);
      #1;
      chk_outputs($sformatf("miss%0d", i), 0, 64'h0, 64'h2000, 0, 0, 32'(1 + i));
      next_cycle();
    end
    // Hit while in MISS: push 0x2000 this cycle, decode stalled so it stays.
    drive(0,1,0,64'h0,0);
    #1;
    chk_outputs("miss_hit", 0, 64'h0, 64'h2000, 0, 0, 7);
    next_cycle();
    // Exactly one entry; another miss begins.
    drive(0,0,0,64'h0,0);
    #1;
    chk_outputs("miss_after", 1, 64'h2000, 64'h2004, 0, 0, 8);
    next_cycle();
    chk_outputs("miss_again", 1, 64'h2000, 64'h2004, 0, 0, 8);

    // Asynchronous reset in the middle of a MISS cycle.
    #2;
    reset_n = 1'b0;
    #1;
    chk_outputs("async_reset", 0, 64'h0, 64'h0, 1, 0, 0);
    next_cycle();
    reset_n = 1'b1;
    drive(1,1,0,64'h0,0);
    #1;
    chk_outputs("reboot_boot", 0, 64'h0, 64'h0, 1, 0, 0);
    next_cycle();
    chk_outputs("reboot_fetch", 0, 64'h0, 64'h0, 0, 0, 0);
    next_cycle();
    chk_outputs("reboot_first", 1, 64'h0, 64'h4, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the instruction cache and downstream of the branch/exception redirect logic. It owns the program counter, drives the cache lookup address, and captures each cache hit into a small in-order fetch queue of {pc, instruction} pairs. Decode consumes from that queue with a valid/ready handshake. It also converts pipeline redirects into PC reloads plus queue flushes, and converts fence.i requests into a one-cycle cache flush pulse.

## Interface
- ADDR_WIDTH, 64, PC/address width
- RESET_PC, 64'h0, PC loaded at reset (bits [1:0] must be 0)
- QUEUE_DEPTH, 4, fetch-queue entries (power of two, ≥2)
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- icache_addr  out  ADDR_WIDTH  lookup address to the cache (= pc)
- icache_instr  in  32  instruction word from the cache, same-cycle combinational
- icache_valid  in  1  cache hit for icache_addr this cycle
- icache_stall  out  1  asks the cache not to start a refill
- icache_flush  out  1  cache flush request, one-cycle pulse
- redirect_valid  in  1  load new PC and discard queued/in-flight fetches
- redirect_pc  in  ADDR_WIDTH  target PC; bits [1:0] ignored (forced 0)
- fence_i  in  1  request cache flush (single-cycle pulse expected)
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_pc  out  ADDR_WIDTH  PC of head entry
- out_instr  out  32  instruction of head entry
- miss_cycles  out  32  saturating count of cycles spent in MISS

## Operation
- Reset values: pc=RESET_PC, queue empty, state=BOOT, out_valid=0, out_pc=0, out_instr=0, icache_stall=1, icache_flush=0, miss_cycles=0. icache_addr=pc at all times.
- Queue: circular buffer with wr_ptr/rd_ptr of log2(QUEUE_DEPTH)+1 bits. Full when indices are equal and wrap bits differ; empty when both are equal. Head is exposed combinationally. Unused entries read as 0.
- pop = out_valid & out_ready.
- can_push = !full | pop. Push while full is allowed only when a pop occurs in the same cycle.
- FSM:
  - BOOT: single cycle after reset, no fetch; goes to FETCH.
  - FETCH: if icache_valid & can_push, push {pc, icache_instr} and set pc += 4. If !icache_valid, go to MISS. If icache_valid & !can_push, go to FULL.
  - MISS: no push, miss_cycles += 1 (saturates at 32'hFFFF_FFFF). When icache_valid is seen, behave as in FETCH (push that cycle if can_push) and leave MISS.
  - FULL: no push. When can_push and icache_valid, push and go to FETCH. When can_push and !icache_valid, go to MISS.
  - FLUSHING: entered on fence_i. Holds exactly 2 cycles (counter), with no push. icache_flush=1 in the first cycle only. Then goes to FETCH.
- icache_stall = (state==BOOT) | (state==FULL) | (state==FLUSHING) | full.
- Priority when several events occur in one cycle: reset > redirect > fence_i > fetch/pop.
  - redirect: pc ← {redirect_pc[ADDR_WIDTH-1:2],2'b0}, queue cleared (ptrs ← 0, a concurrent pop is discarded), no push this cycle, state ← FETCH. This aborts FLUSHING; icache_flush drops.
  - fence_i (no redirect): queue is not cleared, pc is held, state ← FLUSHING.
- pc wraps modulo 2^ADDR_WIDTH; there is no overflow flag.

## Timing
- Hit path: icache_addr→icache_valid/icache_instr is combinational in the same cycle. The queue write happens at the rising edge, so an entry appears on out_valid the next cycle (1-cycle fetch-to-decode latency when the queue is empty).
- Sustained throughput is 1 instruction/cycle while hits continue and out_ready=1.
- Redirect takes effect at the edge. The next cycle, icache_addr=new pc and out_valid=0.
- icache_flush is high exactly one cycle, the cycle after fence_i is sampled.
- Asserting reset_n low mid-miss or mid-flush clears everything asynchronously. Outputs take reset values immediately.

## Test plan
- Reset/boot: hold reset_n=0, release, then return hits for 4 words at 0x0,4,8,C with out_ready=1 → out_pc sequence 0x0,0x4,0x8,0xC on consecutive cycles starting 2 cycles after release; out_instr matches the data supplied.
- Backpressure: out_ready=0 with hits → exactly 4 pushes, state FULL, icache_stall=1, pc=0x10. Then out_ready=1 for 1 cycle → pop and push in the same cycle, and the queue stays full.
- Miss: icache_valid=0 for 7 cycles then 1 → miss_cycles=7, one push at the correct pc, no duplicate entries.
- Redirect with the queue holding 3 entries and a concurrent pop: redirect_pc=0x1003 → queue empty next cycle, icache_addr=0x1000, first new out_pc=0x1000.
- fence_i: icache_flush=1 for exactly one cycle, no pushes for 2 cycles, queued entries preserved. A redirect during FLUSHING aborts it immediately.
- Asynchronous reset: drop reset_n during MISS → all outputs reach reset values before the next clk edge.
